// File: rtl/board_pkg.sv
// Shared cell-state type, board geometry and colour constants for the
// board colouring stage and its cell memory.
package board_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHIP  = 2'd1,
        HIT   = 2'd2,
        MISS  = 2'd3
    } cell_state_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } sweep_state_t;

    localparam int BOARD_CELLS = 12;
    localparam int CELL_PX     = 32;
    localparam int LINE_PX     = 2;
    localparam int BOARD_PX    = 386;
    localparam int CELL_SHIFT  = $clog2(CELL_PX);
    localparam int RAM_DEPTH   = BOARD_CELLS * BOARD_CELLS;

    localparam logic [11:0] RGB_BLANK  = 12'h000;
    localparam logic [11:0] RGB_SHIP   = 12'h888;
    localparam logic [11:0] RGB_HIT    = 12'hF00;
    localparam logic [11:0] RGB_MISS   = 12'h00F;
    localparam logic [11:0] RGB_CURSOR = 12'hFF0;

    function automatic logic [7:0] cell_addr(input logic [3:0] col, input logic [3:0] row);
        return {4'd0, row} * 8'd12 + {4'd0, col};
    endfunction

    // Two-pixel frame hugging the inside of the grid lines on each side.
    function automatic logic is_frame(input logic [4:0] p);
        return p inside {5'd2, 5'd3, 5'd30, 5'd31};
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pixel-chain bus: pixel counters, syncs, blanking and 12-bit colour.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/board_ram.sv
// 144 x 2-bit cell-state memory: one synchronous write port, one synchronous
// read port, read-first on a same-address collision.
module board_ram
    import board_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  cell_state_t wdata,
    input  logic [7:0]  raddr,
    output cell_state_t rdata
);

    cell_state_t mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/draw_board.sv
// Colours board cell interiors from the cell-state memory, two-cycle pixel
// pipeline; optional cursor frame when BOARD_CURSOR_EN is defined.
module draw_board
    import board_pkg::*;
#(
    parameter int X_POS = 0,
    parameter int Y_POS = 0
) (
    input  logic       clk,
    input  logic       rst,
    vga_if.in          in,
    vga_if.out         out,
    input  logic       wr_req,
    input  logic [3:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic [1:0] wr_state,
    output logic       wr_ack,
    input  logic       clr_req,
    output logic       busy
`ifdef BOARD_CURSOR_EN
    ,
    input  logic [3:0] cursor_x,
    input  logic [3:0] cursor_y
`endif
);

    logic [10:0] lx, ly;
    logic [3:0]  col, row;
    logic        interior, cursor_hit;
    logic [7:0]  pix_addr;

    always_comb begin
        lx  = in.hcount - 11'(X_POS);
        ly  = in.vcount - 11'(Y_POS);
        col = lx[CELL_SHIFT +: 4];
        row = ly[CELL_SHIFT +: 4];
        interior = (lx < 11'(BOARD_PX)) && (ly < 11'(BOARD_PX)) &&
                   (col < 4'(BOARD_CELLS)) && (row < 4'(BOARD_CELLS)) &&
                   (lx[CELL_SHIFT-1:0] >= 5'(LINE_PX)) &&
                   (ly[CELL_SHIFT-1:0] >= 5'(LINE_PX));
        pix_addr = interior ? cell_addr(col, row) : '0;
`ifdef BOARD_CURSOR_EN
        // col/row < 12 inside an interior, so out-of-range cursors never match.
        cursor_hit = interior && (col == cursor_x) && (row == cursor_y) &&
                     (is_frame(lx[CELL_SHIFT-1:0]) || is_frame(ly[CELL_SHIFT-1:0]));
`else
        cursor_hit = 1'b0;
`endif
    end

    sweep_state_t state;
    logic [7:0]   clr_addr;
    logic         ram_we;
    logic [7:0]   ram_waddr;
    cell_state_t  ram_wdata, ram_rdata;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_addr;
        ram_wdata = EMPTY;
        if (state == CLEAR) begin
            ram_we = 1'b1;
        end else if (!clr_req && wr_req &&
                     (wr_x < 4'(BOARD_CELLS)) && (wr_y < 4'(BOARD_CELLS))) begin
            ram_we    = 1'b1;
            ram_waddr = cell_addr(wr_x, wr_y);
            ram_wdata = cell_state_t'(wr_state);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
            wr_ack   <= 1'b0;
        end else begin
            wr_ack <= 1'b0;
            case (state)
                CLEAR: begin
                    if (clr_addr == 8'(RAM_DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 8'd1;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                        busy     <= 1'b1;
                    end else if (wr_req) begin
                        wr_ack <= 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    board_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (pix_addr),
        .rdata (ram_rdata)
    );

    logic [10:0] s1_hcount, s1_vcount;
    logic        s1_hsync, s1_vsync, s1_hblnk, s1_vblnk;
    logic [11:0] s1_rgb;
    logic        s1_interior, s1_cursor, s1_blank, s1_force_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_hcount      <= '0;
            s1_vcount      <= '0;
            s1_hsync       <= 1'b0;
            s1_vsync       <= 1'b0;
            s1_hblnk       <= 1'b0;
            s1_vblnk       <= 1'b0;
            s1_rgb         <= '0;
            s1_interior    <= 1'b0;
            s1_cursor      <= 1'b0;
            s1_blank       <= 1'b0;
            s1_force_empty <= 1'b0;
        end else begin
            s1_hcount      <= in.hcount;
            s1_vcount      <= in.vcount;
            s1_hsync       <= in.hsync;
            s1_vsync       <= in.vsync;
            s1_hblnk       <= in.hblnk;
            s1_vblnk       <= in.vblnk;
            s1_rgb         <= in.rgb;
            s1_interior    <= interior;
            s1_cursor      <= cursor_hit;
            s1_blank       <= in.hblnk | in.vblnk;
            // RAM holds stale or undefined data until the sweep finishes.
            s1_force_empty <= (state == CLEAR);
        end
    end

    cell_state_t shown;
    logic [11:0] pix_rgb;

    always_comb begin
        shown   = s1_force_empty ? EMPTY : ram_rdata;
        pix_rgb = s1_rgb;
        if (s1_blank) begin
            pix_rgb = RGB_BLANK;
        end else if (s1_cursor) begin
            pix_rgb = RGB_CURSOR;
        end else if (s1_interior) begin
            case (shown)
                SHIP:    pix_rgb = RGB_SHIP;
                HIT:     pix_rgb = RGB_HIT;
                MISS:    pix_rgb = RGB_MISS;
                default: pix_rgb = s1_rgb;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= s1_hcount;
            out.vcount <= s1_vcount;
            out.hsync  <= s1_hsync;
            out.vsync  <= s1_vsync;
            out.hblnk  <= s1_hblnk;
            out.vblnk  <= s1_vblnk;
            out.rgb    <= pix_rgb;
        end
    end

endmodule

// File: tb/tb_draw_board.sv
// Self-checking bench for draw_board: random pixels against a geometric
// reference model of the board, plus write/clear/reset control scenarios.
module tb_draw_board;

    localparam int X_POS = 100;
    localparam int Y_POS = 40;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } vrec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_req = 1'b0;
    logic [3:0] wr_x = '0;
    logic [3:0] wr_y = '0;
    logic [1:0] wr_state = '0;
    logic       wr_ack;
    logic       clr_req = 1'b0;
    logic       busy;
`ifdef BOARD_CURSOR_EN
    logic [3:0] cursor_x = 4'd15;
    logic [3:0] cursor_y = 4'd15;
`endif

    vga_if vin ();
    vga_if vout ();

    int compared = 0;
    int mismatched = 0;
    int board_m [144];

    draw_board #(.X_POS(X_POS), .Y_POS(Y_POS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (vin),
        .out      (vout),
        .wr_req   (wr_req),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_state (wr_state),
        .wr_ack   (wr_ack),
        .clr_req  (clr_req),
        .busy     (busy)
`ifdef BOARD_CURSOR_EN
        ,
        .cursor_x (cursor_x),
        .cursor_y (cursor_y)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: what the pixel should look like after the board stage.
    function automatic vrec_t model(input vrec_t p);
        vrec_t e;
        int lx, ly, col, row, fx, fy;
        e  = p;
        lx = (int'(p.h) - X_POS) & 2047;
        ly = (int'(p.v) - Y_POS) & 2047;
        if (p.hb || p.vb) begin
            e.rgb = 12'h000;
            return e;
        end
        if (lx >= 386 || ly >= 386) return e;
        col = lx / 32; row = ly / 32; fx = lx % 32; fy = ly % 32;
        if (col >= 12 || row >= 12 || fx < 2 || fy < 2) return e;
`ifdef BOARD_CURSOR_EN
        if (col == int'(cursor_x) && row == int'(cursor_y) &&
            (fx == 2 || fx == 3 || fx == 30 || fx == 31 ||
             fy == 2 || fy == 3 || fy == 30 || fy == 31)) begin
            e.rgb = 12'hFF0;
            return e;
        end
`endif
        case (board_m[row * 12 + col])
            1: e.rgb = 12'h888;
            2: e.rgb = 12'hF00;
            3: e.rgb = 12'h00F;
            default: ;
        endcase
        return e;
    endfunction

    function automatic vrec_t rand_rec();
        vrec_t r;
        r.h   = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 2047)) : 11'(X_POS - 4 + int'($urandom_range(0, 400)));
        r.v   = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 2047)) : 11'(Y_POS - 4 + int'($urandom_range(0, 400)));
        r.hs  = 1'($urandom);
        r.vs  = 1'($urandom);
        r.hb  = ($urandom_range(0, 7) == 0);
        r.vb  = ($urandom_range(0, 7) == 0);
        r.rgb = 12'($urandom);
        return r;
    endfunction

    function automatic vrec_t at(input int lx, input int ly);
        vrec_t r;
        r.h   = 11'(X_POS + lx);
        r.v   = 11'(Y_POS + ly);
        r.hs  = 1'($urandom);
        r.vs  = 1'($urandom);
        r.hb  = 1'b0;
        r.vb  = 1'b0;
        r.rgb = 12'($urandom_range(1, 4095));
        return r;
    endfunction

    function automatic vrec_t obs();
        return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
    endfunction

    task automatic drive_rec(input vrec_t r);
        vin.hcount = r.h;  vin.vcount = r.v;
        vin.hsync  = r.hs; vin.vsync  = r.vs;
        vin.hblnk  = r.hb; vin.vblnk  = r.vb;
        vin.rgb    = r.rgb;
    endtask

    // One write request cycle in IDLE; returns at the negedge after the accepting edge.
    task automatic drive_write(input int x, input int y, input int s);
        @(negedge clk);
        wr_req = 1'b1; wr_x = 4'(x); wr_y = 4'(y); wr_state = 2'(s);
        @(negedge clk);
        wr_req = 1'b0;
        if (x < 12 && y < 12) board_m[y * 12 + x] = s;
    endtask

    task automatic test_reset();
        vrec_t expq[$];
        vrec_t p, e;
        int cnt;
        rst = 1'b1;
        drive_rec(rand_rec());
        #2 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            drive_rec(rand_rec());
            compared++;
            if (obs() !== '0) begin
                mismatched++;
                $display("FAIL reset_out: got %h expected 0", obs());
            end
            compared++;
            if (wr_ack !== 1'b0 || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL reset_ctrl: wr_ack=%b busy=%b expected 0/1", wr_ack, busy);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        foreach (board_m[i]) board_m[i] = 0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 300) begin
            if (cnt >= 2) begin
                e = expq.pop_front();
                compared++;
                if (obs() !== e) begin
                    mismatched++;
                    $display("FAIL reset_sweep_pixel: got %h expected %h", obs(), e);
                end
            end
            p = ($urandom_range(0, 1) == 0) ? at($urandom_range(0, 385), $urandom_range(0, 385)) : rand_rec();
            drive_rec(p);
            expq.push_back(model(p));
            cnt++;
            @(negedge clk);
        end
        for (int k = 0; k < 2 && expq.size() > 0; k++) begin
            if (k == 1) @(negedge clk);
            e = expq.pop_front();
            compared++;
            if (obs() !== e) begin
                mismatched++;
                $display("FAIL reset_sweep_tail: got %h expected %h", obs(), e);
            end
        end
        compared++;
        if (cnt != 144) begin
            mismatched++;
            $display("FAIL reset_busy_len: got %0d cycles expected 144", cnt);
        end
    endtask

    task automatic test_write_ship();
        vrec_t stim[$];
        vrec_t expq[$];
        vrec_t e;
        drive_write(3, 5, 1);
        compared++;
        if (wr_ack !== 1'b1) begin
            mismatched++;
            $display("FAIL ship_ack: got %b expected 1", wr_ack);
        end
        @(negedge clk);
        compared++;
        if (wr_ack !== 1'b0) begin
            mismatched++;
            $display("FAIL ship_ack_pulse: got %b expected 0", wr_ack);
        end
        stim.push_back(at(3 * 32 + 10, 5 * 32 + 10));
        stim.push_back(at(96, 5 * 32 + 10));
        stim.push_back(at(3 * 32 + 2, 5 * 32 + 31));
        stim.push_back(at(3 * 32 + 1, 5 * 32 + 10));
        repeat (20) stim.push_back(rand_rec());
        for (int i = 0; i < stim.size() + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = expq.pop_front();
                compared++;
                if (obs() !== e) begin
                    mismatched++;
                    $display("FAIL ship_pixel[%0d]: got %h expected %h", i - 2, obs(), e);
                end
            end
            if (i < stim.size()) begin
                drive_rec(stim[i]);
                expq.push_back(model(stim[i]));
            end
        end
    endtask

    task automatic test_hit_miss_random();
        vrec_t stim[$];
        vrec_t expq[$];
        vrec_t e;
        drive_write(0, 0, 2);
        drive_write(11, 11, 3);
        for (int r = 0; r < 3; r++) begin
            repeat (6) begin
                drive_write($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 3));
                compared++;
                if (wr_ack !== 1'b1) begin
                    mismatched++;
                    $display("FAIL rand_write_ack: got %b expected 1", wr_ack);
                end
            end
            stim.delete();
            expq.delete();
            if (r == 0) begin
                stim.push_back(at(2, 2));
                stim.push_back(at(383, 383));
                stim.push_back(at(386, 10));
                stim.push_back(at(10, 386));
            end
            repeat (30) stim.push_back(rand_rec());
            repeat (30) stim.push_back(at($urandom_range(0, 385), $urandom_range(0, 385)));
            for (int i = 0; i < stim.size() + 2; i++) begin
                @(negedge clk);
                if (i >= 2) begin
                    e = expq.pop_front();
                    compared++;
                    if (obs() !== e) begin
                        mismatched++;
                        $display("FAIL hit_miss_pixel[%0d.%0d]: got %h expected %h", r, i - 2, obs(), e);
                    end
                end
                if (i < stim.size()) begin
                    drive_rec(stim[i]);
                    expq.push_back(model(stim[i]));
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        vrec_t stim[$];
        vrec_t expq[$];
        vrec_t e;
        drive_write(12, 3, 2);
        compared++;
        if (wr_ack !== 1'b1) begin
            mismatched++;
            $display("FAIL oor_x_ack: got %b expected 1", wr_ack);
        end
        drive_write(4, 13, 3);
        compared++;
        if (wr_ack !== 1'b1) begin
            mismatched++;
            $display("FAIL oor_y_ack: got %b expected 1", wr_ack);
        end
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++)
                stim.push_back(at(c * 32 + 16, r * 32 + 16));
        for (int i = 0; i < stim.size() + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = expq.pop_front();
                compared++;
                if (obs() !== e) begin
                    mismatched++;
                    $display("FAIL oor_board_scan[%0d]: got %h expected %h", i - 2, obs(), e);
                end
            end
            if (i < stim.size()) begin
                drive_rec(stim[i]);
                expq.push_back(model(stim[i]));
            end
        end
    endtask

    task automatic test_clr_collision();
        vrec_t stim[$];
        vrec_t expq[$];
        vrec_t e;
        int cnt;
        @(negedge clk);
        wr_req = 1'b1; wr_x = 4'd1; wr_y = 4'd1; wr_state = 2'd2; clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        foreach (board_m[i]) board_m[i] = 0;
        compared++;
        if (wr_ack !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL clr_collision: wr_ack=%b busy=%b expected 0/1", wr_ack, busy);
        end
        cnt = 0;
        while (busy === 1'b1 && cnt < 300) begin
            compared++;
            if (wr_ack !== 1'b0) begin
                mismatched++;
                $display("FAIL clr_sweep_ack: got %b expected 0 at cycle %0d", wr_ack, cnt);
            end
            wr_req = 1'b1;
            wr_x = 4'($urandom_range(0, 11)); wr_y = 4'($urandom_range(0, 11));
            wr_state = 2'($urandom_range(1, 3));
            clr_req = 1'($urandom);
            cnt++;
            @(negedge clk);
        end
        wr_req = 1'b0; clr_req = 1'b0;
        compared++;
        if (cnt != 144) begin
            mismatched++;
            $display("FAIL clr_busy_len: got %0d cycles expected 144", cnt);
        end
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++)
                stim.push_back(at(c * 32 + $urandom_range(2, 31), r * 32 + $urandom_range(2, 31)));
        for (int i = 0; i < stim.size() + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = expq.pop_front();
                compared++;
                if (obs() !== e) begin
                    mismatched++;
                    $display("FAIL clr_board_scan[%0d]: got %h expected %h", i - 2, obs(), e);
                end
            end
            if (i < stim.size()) begin
                drive_rec(stim[i]);
                expq.push_back(model(stim[i]));
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        vrec_t expq[$];
        vrec_t p, e;
        int cnt;
        drive_write(10, 10, 1);
        drive_write(11, 8, 2);
        drive_write(5, 11, 3);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        foreach (board_m[i]) board_m[i] = 0;
        repeat (69) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            compared++;
            if (obs() !== '0 || busy !== 1'b1 || wr_ack !== 1'b0) begin
                mismatched++;
                $display("FAIL midreset_hold: out=%h busy=%b wr_ack=%b expected 0/1/0", obs(), busy, wr_ack);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 300) begin
            if (cnt >= 2) begin
                e = expq.pop_front();
                compared++;
                if (obs() !== e) begin
                    mismatched++;
                    $display("FAIL midreset_pixel: got %h expected %h", obs(), e);
                end
            end
            compared++;
            if (wr_ack !== 1'b0) begin
                mismatched++;
                $display("FAIL midreset_ack: got %b expected 0 at cycle %0d", wr_ack, cnt);
            end
            case (cnt % 4)
                0: p = at(10 * 32 + $urandom_range(2, 31), 10 * 32 + $urandom_range(2, 31));
                1: p = at(11 * 32 + $urandom_range(2, 31), 8 * 32 + $urandom_range(2, 31));
                2: p = at(5 * 32 + $urandom_range(2, 31), 11 * 32 + $urandom_range(2, 31));
                default: p = rand_rec();
            endcase
            drive_rec(p);
            expq.push_back(model(p));
            wr_req = 1'b1;
            wr_x = 4'($urandom_range(0, 15)); wr_y = 4'($urandom_range(0, 15));
            wr_state = 2'($urandom_range(1, 3));
            cnt++;
            @(negedge clk);
        end
        wr_req = 1'b0;
        for (int k = 0; k < 2 && expq.size() > 0; k++) begin
            if (k == 1) @(negedge clk);
            e = expq.pop_front();
            compared++;
            if (obs() !== e) begin
                mismatched++;
                $display("FAIL midreset_tail: got %h expected %h", obs(), e);
            end
        end
        compared++;
        if (cnt != 144) begin
            mismatched++;
            $display("FAIL midreset_busy_len: got %0d cycles expected 144", cnt);
        end
    endtask

`ifdef BOARD_CURSOR_EN
    task automatic test_cursor();
        vrec_t stim[$];
        vrec_t expq[$];
        vrec_t e;
        drive_write(2, 2, 1);
        cursor_x = 4'd2; cursor_y = 4'd2;
        stim.push_back(at(66, 80));
        stim.push_back(at(80, 80));
        stim.push_back(at(95, 70));
        stim.push_back(at(70, 64));
        repeat (30) stim.push_back(at(64 + $urandom_range(0, 31), 64 + $urandom_range(0, 31)));
        for (int i = 0; i < stim.size() + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = expq.pop_front();
                compared++;
                if (obs() !== e) begin
                    mismatched++;
                    $display("FAIL cursor_pixel[%0d]: got %h expected %h", i - 2, obs(), e);
                end
            end
            if (i < stim.size()) begin
                drive_rec(stim[i]);
                expq.push_back(model(stim[i]));
            end
        end
        cursor_x = 4'd12; cursor_y = 4'd2;
        stim.delete();
        stim.push_back(at(66, 80));
        repeat (20) stim.push_back(at($urandom_range(0, 385), $urandom_range(0, 385)));
        for (int i = 0; i < stim.size() + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = expq.pop_front();
                compared++;
                if (obs() !== e) begin
                    mismatched++;
                    $display("FAIL cursor_off_pixel[%0d]: got %h expected %h", i - 2, obs(), e);
                end
            end
            if (i < stim.size()) begin
                drive_rec(stim[i]);
                expq.push_back(model(stim[i]));
            end
        end
        cursor_x = 4'd15; cursor_y = 4'd15;
    endtask
`endif

    initial begin
        drive_rec('0);
        test_reset();
        test_write_ship();
        test_hit_miss_random();
        test_out_of_range();
        test_clr_collision();
        test_reset_mid_sweep();
`ifdef BOARD_CURSOR_EN
        test_cursor();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
